// File: rtl/sound_latch.sv
// 68k -> Z80 sound command mailbox: one command byte, pending/overrun status,
// and a level Z80 /INT driven while a command waits.
module sound_latch #(
  parameter int unsigned DATA_W        = 8,
  parameter bit          CLEAR_ON_READ = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m68k_latch_cs,
  input  logic              m68k_sound_cs,
  input  logic              m68k_lds_n,
  input  logic [DATA_W-1:0] m68k_din,
  output logic [DATA_W-1:0] m68k_dout,
  input  logic              z80_latch_cs,
  input  logic              RD_n,
  input  logic              WR_n,
  input  logic              M1_n,
  input  logic              IORQ_n,
  output logic [DATA_W-1:0] z80_dout,
  output logic              z80_int_n,
  output logic              pending,
  output logic              overrun
);

  logic [DATA_W-1:0] r_latch_data;
  logic              r_pending;
  logic              r_overrun;
  logic              r_int_n;
  logic              r_w68_hist;
  logic              r_czw_hist;
  logic              r_czr_hist;
  logic              r_snd_hist;

  logic w_w68_lvl, w_czw_lvl, w_czr_lvl;
  logic w_w68, w_cz, w_snd_fall;
  logic w_pending_nxt, w_overrun_nxt;
  logic w_unused;

  // Interrupt acknowledge is IM1 and never touches the mailbox.
  assign w_unused = &{1'b0, M1_n, IORQ_n};

  assign w_w68_lvl  = m68k_latch_cs & ~m68k_lds_n;
  assign w_czw_lvl  = z80_latch_cs & ~WR_n;
  assign w_czr_lvl  = z80_latch_cs & ~RD_n;

  // One event per bus cycle: rising edge of each qualified select.
  assign w_w68      = w_w68_lvl & ~r_w68_hist;
  assign w_cz       = (w_czw_lvl & ~r_czw_hist) |
                      (CLEAR_ON_READ & w_czr_lvl & ~r_czr_hist);
  assign w_snd_fall = r_snd_hist & ~m68k_sound_cs;

  // Write beats clear; overrun set beats the end-of-status-read clear.
  always_comb begin
    w_pending_nxt = r_pending;
    w_overrun_nxt = r_overrun;
    if (w_cz) begin
      w_pending_nxt = 1'b0;
    end
    if (w_w68) begin
      w_pending_nxt = 1'b1;
    end
    if (w_snd_fall) begin
      w_overrun_nxt = 1'b0;
    end
    if (w_w68 && r_pending && !w_cz) begin
      w_overrun_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_latch_data <= '0;
      r_pending    <= 1'b0;
      r_overrun    <= 1'b0;
      r_int_n      <= 1'b1;
      r_w68_hist   <= 1'b0;
      r_czw_hist   <= 1'b0;
      r_czr_hist   <= 1'b0;
      r_snd_hist   <= 1'b0;
    end else begin
      r_w68_hist <= w_w68_lvl;
      r_czw_hist <= w_czw_lvl;
      r_czr_hist <= w_czr_lvl;
      r_snd_hist <= m68k_sound_cs;
      r_pending  <= w_pending_nxt;
      r_overrun  <= w_overrun_nxt;
      r_int_n    <= ~w_pending_nxt;
      if (w_w68) begin
        r_latch_data <= m68k_din;
      end
    end
  end

  // Read muxes return zero when not selected so they can be OR-ed upstream.
  always_comb begin
    z80_dout  = '0;
    m68k_dout = '0;
    if (z80_latch_cs && !RD_n) begin
      z80_dout = r_latch_data;
    end
    if (m68k_sound_cs) begin
      m68k_dout[1] = r_overrun;
      m68k_dout[0] = r_pending;
    end
  end

  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign z80_int_n = r_int_n;

endmodule
